// File: rtl/sample_fetcher.sv
// sample_fetcher: read-side client of the sample memory.
// Walks `address` upward from row 0. Each IN_DIM-word row is captured from
// the memory's combinational data into `sample` and offered to the
// inference datapath over a valid/ready handshake. A pass ends when word 0
// of the addressed row equals TERM_MARKER, or when the address reaches
// MEM_DEPTH without a marker; the second case also raises `overflow`.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse; starts a pass from row 0 (IDLE/DONE only)
//   address        row index driven to the memory
//   mem_data       row contents, combinational in address
//   sample         registered copy of the current row
//   sample_valid   sample holds an unconsumed row
//   sample_ready   consumer accepts the row when high with sample_valid
//   sample_count   rows accepted since the last start
//   busy           pass in progress (FETCH or VALID)
//   done           pass finished; held until the next start or rst
//   overflow       pass ended at MEM_DEPTH without a marker
module sample_fetcher #(
  parameter int                IN_DIM      = 4,
  parameter int                DATA_W      = 16,
  parameter logic [31:0]       MEM_DEPTH   = 32'd10000,
  parameter logic [DATA_W-1:0] TERM_MARKER = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [31:0]       address,
  input  logic [DATA_W-1:0] mem_data [IN_DIM],
  output logic [DATA_W-1:0] sample   [IN_DIM],
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [31:0]       sample_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} state_t;
  state_t state;

  // Row decode during FETCH; the marker check outranks the depth limit so
  // a marker sitting exactly at MEM_DEPTH still ends the pass cleanly.
  logic is_marker, at_depth, row_load;
  assign is_marker = (mem_data[0] == TERM_MARKER);
  assign at_depth  = (address == MEM_DEPTH);
  assign row_load  = (state == FETCH) && !is_marker && !at_depth;

  // Per-word capture lanes: every word of the row loads on the same edge.
  for (genvar g = 0; g < IN_DIM; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)           sample[g] <= '0;
      else if (row_load) sample[g] <= mem_data[g];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      address      <= '0;
      sample_valid <= 1'b0;
      sample_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            address      <= '0;
            sample_count <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (is_marker || at_depth) begin
            done     <= 1'b1;
            overflow <= !is_marker;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            sample_valid <= 1'b1;
            state        <= VALID;
          end
        end
        VALID: begin
          // Hold row and address until the consumer takes it.
          if (sample_ready) begin
            sample_valid <= 1'b0;
            address      <= address + 32'd1;
            sample_count <= sample_count + 32'd1;
            state        <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fetcher.sv
module tb_sample_fetcher;
  localparam int IN_DIM = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, sample_ready;
  logic [31:0]       address, sample_count;
  logic [DATA_W-1:0] mem_data [IN_DIM];
  logic [DATA_W-1:0] sample   [IN_DIM];
  logic              sample_valid, busy, done, overflow;

  // Sample memory: 16 rows is ample since address never exceeds DEPTH.
  logic [DATA_W-1:0] mem [16][IN_DIM];
  always_comb
    for (int i = 0; i < IN_DIM; i++) mem_data[i] = mem[address[3:0]][i];

  sample_fetcher #(
    .IN_DIM(IN_DIM), .DATA_W(DATA_W), .MEM_DEPTH(32'(DEPTH)), .TERM_MARKER(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .address(address),
    .mem_data(mem_data), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_count(sample_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // Cycle model: observable flags only, advanced from the rules of the block.
  logic [31:0]       m_addr, m_count;
  logic              m_valid, m_busy, m_done, m_ovf;
  logic [DATA_W-1:0] m_sample [IN_DIM];

  // Transaction scoreboard: the rows a pass must deliver, worked out up front.
  int sb_q[$];
  int sb_len, hs_seen;
  bit sb_ovf;
  logic prev_done;

  task automatic sb_build();
    sb_q.delete();
    sb_ovf = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (mem[r][0] == 16'hFFFF) break;
      if (r == DEPTH) begin sb_ovf = 1'b1; break; end
      sb_q.push_back(r);
    end
    sb_len = sb_q.size();
  endtask

  task automatic step();
    int r;
    if (!rst && sample_valid && sample_ready) begin
      hs_seen++;
      if (sb_q.size() == 0) fail("hs_unexpected");
      else begin
        r = sb_q.pop_front();
        chk("hs_addr", address, 64'(r));
        for (int i = 0; i < IN_DIM; i++) chk("hs_word", sample[i], mem[r][i]);
      end
    end
    if (rst) begin
      m_addr = 0; m_count = 0; m_valid = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      for (int i = 0; i < IN_DIM; i++) m_sample[i] = '0;
      sb_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_addr = 0; m_count = 0; m_done = 0; m_ovf = 0; m_busy = 1;
        sb_build();
        hs_seen = 0;
      end
    end else if (m_valid) begin
      if (sample_ready) begin
        m_valid = 0; m_addr = m_addr + 1; m_count = m_count + 1;
      end
    end else begin
      if (mem[m_addr[3:0]][0] == 16'hFFFF) begin
        m_busy = 0; m_done = 1; m_ovf = 0;
      end else if (m_addr == DEPTH) begin
        m_busy = 0; m_done = 1; m_ovf = 1;
      end else begin
        for (int i = 0; i < IN_DIM; i++) m_sample[i] = mem[m_addr[3:0]][i];
        m_valid = 1;
      end
    end
    prev_done = done;
    @(posedge clk);
    #1;
    chk("address", address, m_addr);
    chk("sample_valid", sample_valid, m_valid);
    chk("sample_count", sample_count, m_count);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    for (int i = 0; i < IN_DIM; i++) chk("sample", sample[i], m_sample[i]);
    if (done && !prev_done) begin
      chk("end_count", sample_count, 64'(sb_len));
      chk("end_addr", address, 64'(sb_len));
      chk("end_ovf", overflow, sb_ovf);
      chk("end_left", 64'(sb_q.size()), 0);
    end
  endtask

  // Rows 0..n-1 get random data with word 0 never the marker.
  task automatic load_rows(input int n, input bit marker);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < IN_DIM; i++) mem[r][i] = 16'($urandom);
    for (int r = 0; r < 16; r++) if (mem[r][0] == 16'hFFFF) mem[r][0] = 16'h0;
    if (marker) mem[n][0] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin step(); k++; end
    if (!done) fail("timeout_done");
  endtask

  task automatic run_to_row(input int row);
    int k = 0;
    while (!(sample_valid && address == 32'(row)) && k < 40) begin step(); k++; end
    if (!(sample_valid && address == 32'(row))) fail("timeout_row");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_ready = 1'b0;
    hs_seen = 0; prev_done = 1'b0;
    load_rows(3, 1);
    step(); step();
    chk("rst_addr", address, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Three rows then the marker, ready high.
    sample_ready = 1'b1;
    pulse_start();
    step();
    chk("s1_first_valid", sample_valid, 1);
    run_done(50);
    chk("s1_count", sample_count, 3);
    chk("s1_addr", address, 3);
    chk("s1_ovf", overflow, 0);
    chk("s1_hs", 64'(hs_seen), 3);

    // Backpressure on row 1 for five cycles.
    load_rows(3, 1);
    pulse_start();
    run_to_row(1);
    sample_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("s2_stall_valid", sample_valid, 1);
      chk("s2_stall_addr", address, 1);
    end
    sample_ready = 1'b1;
    run_done(50);
    chk("s2_hs", 64'(hs_seen), 3);

    // Marker at row 0: done two cycles after start, nothing delivered.
    load_rows(0, 1);
    pulse_start();
    step();
    chk("s3_done", done, 1);
    chk("s3_count", sample_count, 0);
    chk("s3_hs", 64'(hs_seen), 0);

    // No marker: stop at DEPTH with overflow.
    load_rows(5, 0);
    pulse_start();
    run_done(50);
    chk("s4_count", sample_count, 4);
    chk("s4_addr", address, 4);
    chk("s4_ovf", overflow, 1);

    // Marker exactly at DEPTH wins over the limit.
    load_rows(4, 1);
    pulse_start();
    run_done(50);
    chk("s4b_count", sample_count, 4);
    chk("s4b_ovf", overflow, 0);

    // Reset mid-pass at row 2.
    load_rows(3, 1);
    pulse_start();
    run_to_row(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_valid", sample_valid, 0);
    chk("s5_addr", address, 0);
    chk("s5_busy", busy, 0);
    chk("s5_sample0", sample[0], 0);
    pulse_start();
    chk("s5_restart_addr", address, 0);
    chk("s5_restart_count", sample_count, 0);
    run_done(50);
    chk("s5_count", sample_count, 3);

    // Overflow pass, then a start pulsed during VALID is ignored, then a
    // rerun clears done/overflow.
    load_rows(5, 0);
    pulse_start();
    run_done(50);
    load_rows(3, 1);
    pulse_start();
    chk("s6_done_clr", done, 0);
    chk("s6_ovf_clr", overflow, 0);
    for (int k = 0; k < 60 && !done; k++) begin
      start = 1'($urandom);
      sample_ready = 1'($urandom);
      step();
    end
    start = 1'b0;
    if (!done) fail("timeout_s6");
    chk("s6_count", sample_count, 3);
    sample_ready = 1'b1;
    pulse_start();
    run_done(50);
    chk("s6_rerun_count", sample_count, 3);
    chk("s6_rerun_addr", address, 3);

    // Randomized passes.
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(0, 5);
      load_rows(n, n < 5);
      pulse_start();
      for (int k = 0; k < 200 && !done; k++) begin
        sample_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      if (!done) fail("timeout_rand");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_fetcher.md
Name: sample_fetcher

Overview:
Read-side client of the sample memory. Sequences `address` from 0 and captures each `IN_DIM`-word row from the memory's combinational `data_out`. Presents each row to the inference datapath over a valid/ready handshake. Stops at the termination line, where word 0 equals TERM_MARKER, or at MEM_DEPTH rows, whichever comes first.

Parameters:
MEM_DEPTH, 32'd10000, highest legal row index; the fetcher never drives an address above it.
TERM_MARKER, all-ones of `DATA_W, value of word 0 that identifies the termination line.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a pass at row 0; honoured only in IDLE or DONE.
address  output  32  row index driven to the memory.
mem_data  input  `DATA_W x `IN_DIM (unpacked)  row contents from the memory; combinational in `address`.
sample  output  `DATA_W x `IN_DIM (unpacked)  registered copy of the current row.
sample_valid  output  1  sample holds an unconsumed row.
sample_ready  input  1  consumer accepts the row when high with sample_valid.
sample_count  output  32  number of rows accepted since the last start.
busy  output  1  high in FETCH or VALID.
done  output  1  high in DONE; level until the next start or rst.
overflow  output  1  set together with done when MEM_DEPTH was reached without finding the marker.

Behaviour:
- States: IDLE, FETCH, VALID, DONE. All outputs are registered.
- Reset (synchronous; wins over every other input, including mid-pass): state=IDLE; address=0, sample=all zeros, sample_valid=0, sample_count=0, busy=0, done=0, overflow=0.
- IDLE: start=1 -> address=0, sample_count=0, go to FETCH. Otherwise hold.
- FETCH (exactly 1 cycle; address is stable, mem_data settles combinationally):
  - mem_data[0]==TERM_MARKER -> DONE, done=1, overflow=0; sample is not updated.
  - else if address==MEM_DEPTH -> DONE, done=1, overflow=1; sample is not updated. The marker check has priority over this check.
  - else -> sample<=mem_data (all `IN_DIM` words in one edge), sample_valid=1, go to VALID.
- VALID:
  - sample_valid=1; sample and address are held constant.
  - sample_valid does not drop without a handshake.
  - On sample_valid & sample_ready: sample_valid=0, address=address+1, sample_count=sample_count+1, go to FETCH.
  - ready low -> stall indefinitely with no state change.
- DONE:
  - done=1, busy=0; address holds the terminating row index.
  - start=1 -> clear done/overflow, address=0, sample_count=0, go to FETCH.
- start in FETCH or VALID is ignored.
- Latency:
  - start edge -> sample_valid high 2 cycles later (one IDLE->FETCH edge, one FETCH->VALID edge).
  - Handshake edge -> next sample_valid after 2 cycles.
  - Maximum throughput is therefore one row per 2 cycles.
- Arithmetic:
  - address and sample_count are 32-bit unsigned.
  - address never exceeds MEM_DEPTH, so no wrap-around is possible.
  - sample_count equals the number of rows delivered at DONE.
- Only word 0 of a row is compared against the marker. A data row whose word 0 equals TERM_MARKER ends the pass; this is the accepted data constraint.

Test Plan:
All scenarios use `IN_DIM`=4, `DATA_W`=16, TERM_MARKER=16'hFFFF.
1. Memory holds 3 rows then the marker, ready tied high; pulse start -> 3 handshakes delivering rows 0..2 exactly, sample_valid never high on the marker row, done=1, sample_count=3, overflow=0, address=3.
2. Backpressure: ready low for 5 cycles on row 1 -> sample and address stable and sample_valid high throughout; row delivered once when ready rises; no duplicate and no skip.
3. Marker at row 0 -> done=1 two cycles after start, sample_count=0, sample_valid never asserted.
4. MEM_DEPTH=4, no marker in rows 0..4 -> rows 0..3 delivered, then done=1, overflow=1, sample_count=4, address=4.
5. rst asserted in VALID at row 2 -> next cycle all outputs at reset values. A fresh start restarts from address 0 with sample_count=0.
6. start pulses during VALID are ignored. After DONE, a second start reruns scenario 1 with identical results and clears done and overflow.
